// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, frame constants and the XOR key.
// The CPU crypto path imports DEF_KEY from here so both sides decrypt identically.
package prog_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 8;

  localparam logic [BYTE_W-1:0] DEF_SYNC = 8'hA5;
  localparam logic [BYTE_W-1:0] DEF_KEY  = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WR,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  // Same transform the CPU crypto op applies; symmetric, so it both encrypts and decrypts.
  function automatic logic [BYTE_W-1:0] xor_crypt(input logic [BYTE_W-1:0] b,
                                                  input logic [BYTE_W-1:0] key);
    return b ^ key;
  endfunction

endpackage

// File: rtl/prog_byte_dec.sv
// Registered payload decrypt and running checksum for the program loader.
// Decrypted bytes shift into a 16-bit word so {hi, lo} is ready the cycle after the lo byte.
module prog_byte_dec
  import prog_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] KEY = DEF_KEY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic              en,
  input  logic [BYTE_W-1:0] in_data,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum
);

  logic [BYTE_W-1:0] plain_c;

  assign plain_c = xor_crypt(in_data, KEY);

  // Checksum seeds from the plain length byte, then folds in each decrypted payload byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      csum <= '0;
    end else begin
      if (clr) begin
        csum <= '0;
      end else if (ld) begin
        csum <= in_data;
      end else if (en) begin
        csum <= csum ^ plain_c;
      end
      if (en) begin
        word <= {word[BYTE_W-1:0], plain_c};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory writer: parses SYNC/LEN/payload/CSUM frames, decrypts and writes 16-bit words.
// Holds the CPU off via busy while a frame is in flight and reports sticky done/error.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] KEY       = DEF_KEY,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter logic [BYTE_W-1:0] SYNC      = DEF_SYNC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [BYTE_W-1:0] words_loaded
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] len_q, len_d;
  logic              in_ready_d, imem_we_d, busy_d, done_d, error_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [BYTE_W-1:0] words_loaded_d;
  logic              accept_c, dec_clr_c, dec_ld_c, dec_en_c;
  logic [BYTE_W-1:0] wl_inc_c;
  logic [BYTE_W-1:0] csum;

  assign accept_c = in_valid & in_ready;
  assign wl_inc_c = BYTE_W'(words_loaded + BYTE_W'(1));

  prog_byte_dec #(
    .KEY(KEY)
  ) u_dec (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (dec_clr_c),
    .ld      (dec_ld_c),
    .en      (dec_en_c),
    .in_data (in_data),
    .word    (imem_wdata),
    .csum    (csum)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr;
    busy_d         = busy;
    done_d         = done;
    error_d        = error;
    words_loaded_d = words_loaded;
    dec_clr_c      = 1'b0;
    dec_ld_c       = 1'b0;
    dec_en_c       = 1'b0;

    unique case (state_q)
      // Finished states behave like IDLE, except a new SYNC also drops the sticky flags.
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept_c && (in_data == SYNC)) begin
          state_d        = ST_LEN;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          imem_addr_d    = BASE_ADDR;
          dec_clr_c      = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept_c) begin
          len_d    = in_data;
          dec_ld_c = 1'b1;
          if (in_data == '0) begin
            state_d = ST_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (accept_c) begin
          dec_en_c = 1'b1;
          state_d  = ST_LO;
        end
      end
      ST_LO: begin
        if (accept_c) begin
          dec_en_c  = 1'b1;
          imem_we_d = 1'b1;
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        words_loaded_d = wl_inc_c;
        imem_addr_d    = ADDR_W'(imem_addr + ADDR_W'(1));
        state_d        = (wl_inc_c == len_q) ? ST_CSUM : ST_HI;
      end
      ST_CSUM: begin
        if (accept_c) begin
          busy_d = 1'b0;
          if (in_data == csum) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d != ST_WR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      in_ready     <= in_ready_d;
      imem_we      <= imem_we_d;
      imem_addr    <= imem_addr_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= words_loaded_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (BASE 00 and FE) driven by one byte stream,
// checked against a frame-level reference parser.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [7:0] KEY  = 8'h5A;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        rdy0, we0, busy0, done0, err0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [7:0]  addr0, addr1, wl0, wl1;
  logic [15:0] wdata0, wdata1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  wr0_a[$], wr1_a[$];
  logic [15:0] wr0_d[$], wr1_d[$];
  bit          prev_we0, prev_we1;

  logic [15:0] exp_w[$];
  bit          exp_done, exp_err, exp_busy;
  logic [7:0]  exp_wl;
  bit          lo_mark[64];
  int          hdr_idx;

  always #5 clk = ~clk;

  prog_loader #(.KEY(KEY), .BASE_ADDR(8'h00), .SYNC(SYNC)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .busy(busy0), .done(done0),
    .error(err0), .words_loaded(wl0)
  );

  prog_loader #(.KEY(KEY), .BASE_ADDR(8'hFE), .SYNC(SYNC)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .busy(busy1), .done(done1),
    .error(err1), .words_loaded(wl1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle protocol checks and write capture.
  always @(negedge clk) begin
    if (!reset) begin
      prev_we0 = 1'b0;
      prev_we1 = 1'b0;
    end else begin
      chk("rdy_vs_we", 32'(rdy0), 32'(!we0));
      chk("rdy_pair", 32'(rdy1), 32'(rdy0));
      if (we0) begin
        chk("we_width0", 32'(prev_we0), 32'(0));
        wr0_a.push_back(addr0);
        wr0_d.push_back(wdata0);
      end
      if (we1) begin
        chk("we_width1", 32'(prev_we1), 32'(0));
        wr1_a.push_back(addr1);
        wr1_d.push_back(wdata1);
      end
      prev_we0 = we0;
      prev_we1 = we1;
    end
  end

  // Reference: parse one frame (with optional leading garbage) straight from the frame rules.
  task automatic model(input byte_q_t s);
    int i;
    logic [7:0] len, sum, hi, lo;
    exp_w.delete();
    hdr_idx = -1;
    foreach (lo_mark[k]) lo_mark[k] = 1'b0;
    i = 0;
    while (i < s.size() && s[i] != SYNC) i++;
    if (i >= s.size()) return;
    hdr_idx  = i;
    exp_busy = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wl   = 8'h00;
    i++;
    if (i >= s.size()) return;
    len = s[i];
    sum = len;
    i++;
    if (len == 8'h00) begin
      exp_err  = 1'b1;
      exp_busy = 1'b0;
      return;
    end
    for (int k = 0; k < int'(len); k++) begin
      if (i + 1 >= s.size()) return;
      hi = s[i] ^ KEY;
      lo = s[i+1] ^ KEY;
      exp_w.push_back({hi, lo});
      sum = sum ^ hi ^ lo;
      lo_mark[i+1] = 1'b1;
      exp_wl = 8'(k + 1);
      i += 2;
    end
    if (i >= s.size()) return;
    if (s[i] == sum) exp_done = 1'b1;
    else exp_err = 1'b1;
    exp_busy = 1'b0;
  endtask

  task automatic build_frame(input int len, input bit bad, input int garbage, output byte_q_t st);
    logic [7:0] sum, b;
    st = {};
    repeat (garbage) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      st.push_back(b);
    end
    st.push_back(SYNC);
    st.push_back(8'(len));
    sum = 8'(len);
    for (int k = 0; k < 2 * len; k++) begin
      b = 8'($urandom);
      st.push_back(b ^ KEY);
      sum = sum ^ b;
    end
    if (bad) sum = sum ^ 8'($urandom_range(1, 255));
    st.push_back(sum);
  endtask

  // Drive bytes from the negedge; in_ready is registered so it is stable until the next posedge.
  task automatic send_stream(input byte_q_t s, input bit gaps);
    int guard;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = s[i];
      guard = 0;
      while (!rdy0 && guard < 8) begin
        @(negedge clk);
        guard++;
      end
      if (!rdy0) chk("rdy_timeout", 32'(rdy0), 32'(1));
      @(negedge clk);
      if (i < 64 && lo_mark[i]) begin
        chk("we_latency0", 32'(we0), 32'(1));
        chk("we_latency1", 32'(we1), 32'(1));
      end
      if (i == hdr_idx) begin
        chk("busy_hdr", 32'(busy0), 32'(1));
        chk("done_clr", 32'(done0), 32'(0));
        chk("err_clr", 32'(err0), 32'(0));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string t);
    chk({t, "_nwr0"}, 32'(wr0_d.size()), 32'(exp_w.size()));
    chk({t, "_nwr1"}, 32'(wr1_d.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < wr0_d.size(); k++) begin
      chk({t, "_addr0"}, 32'(wr0_a[k]), 32'(8'(k)));
      chk({t, "_data0"}, 32'(wr0_d[k]), 32'(exp_w[k]));
    end
    for (int k = 0; k < exp_w.size() && k < wr1_d.size(); k++) begin
      chk({t, "_addr1"}, 32'(wr1_a[k]), 32'(8'(8'hFE + 8'(k))));
      chk({t, "_data1"}, 32'(wr1_d[k]), 32'(exp_w[k]));
    end
    chk({t, "_done"}, 32'(done0), 32'(exp_done));
    chk({t, "_err"}, 32'(err0), 32'(exp_err));
    chk({t, "_busy"}, 32'(busy0), 32'(exp_busy));
    chk({t, "_wl"}, 32'(wl0), 32'(exp_wl));
    chk({t, "_done1"}, 32'(done1), 32'(exp_done));
    chk({t, "_err1"}, 32'(err1), 32'(exp_err));
    chk({t, "_wl1"}, 32'(wl1), 32'(exp_wl));
  endtask

  task automatic run(input byte_q_t s, input bit gaps, input string t);
    wr0_a.delete(); wr0_d.delete(); wr1_a.delete(); wr1_d.delete();
    model(s);
    send_stream(s, gaps);
    repeat (3) @(negedge clk);
    check_result(t);
  endtask

  task automatic check_reset_vals(input string t);
    chk({t, "_rdy"}, 32'(rdy0), 32'(1));
    chk({t, "_we"}, 32'(we0), 32'(0));
    chk({t, "_addr"}, 32'(addr0), 32'(8'h00));
    chk({t, "_wdata"}, 32'(wdata0), 32'(0));
    chk({t, "_busy"}, 32'(busy0), 32'(0));
    chk({t, "_done"}, 32'(done0), 32'(0));
    chk({t, "_err"}, 32'(err0), 32'(0));
    chk({t, "_wl"}, 32'(wl0), 32'(0));
    chk({t, "_addr1"}, 32'(addr1), 32'(8'hFE));
    chk({t, "_busy1"}, 32'(busy1), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t st;
    int      len, garb;
    bit      bad;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    st = {8'hA5, 8'h02, 8'h48, 8'h6E, 8'hDA, 8'h5A, 8'hA4};
    run(st, 1'b0, "basic");
    if (wr0_d.size() >= 2) begin
      chk("basic_w0", 32'(wr0_d[0]), 32'(16'h1234));
      chk("basic_w1", 32'(wr0_d[1]), 32'(16'h8000));
    end
    chk("basic_done", 32'(done0), 32'(1));

    st = {8'hA5, 8'h02, 8'h48, 8'h6E, 8'hDA, 8'h5A, 8'hA5};
    run(st, 1'b0, "badsum");
    chk("badsum_err", 32'(err0), 32'(1));

    st = {8'hA5, 8'h00};
    run(st, 1'b0, "zlen");
    chk("zlen_err", 32'(err0), 32'(1));

    st = {8'h00, 8'h11, 8'hA5, 8'h01, 8'hA5 ^ KEY, 8'hA5, 8'h01 ^ 8'hA5 ^ (8'hA5 ^ KEY)};
    run(st, 1'b1, "garbage");

    build_frame(3, 1'b0, 0, st);
    run(st, 1'b0, "wrap");
    if (wr1_a.size() == 3) chk("wrap_a2", 32'(wr1_a[2]), 32'(8'h00));

    for (int it = 0; it < 10; it++) begin
      len  = int'($urandom_range(1, 6));
      bad  = ($urandom_range(0, 3) == 0);
      garb = int'($urandom_range(0, 2));
      build_frame(len, bad, garb, st);
      run(st, 1'b0, "rnd");
      run(st, 1'b1, "rndgap");
    end

    // Abort mid-payload with an asynchronous reset between clock edges.
    st = {8'hA5, 8'h04, 8'h11, 8'h22, 8'h33};
    model(st);
    send_stream(st, 1'b0);
    chk("mid_busy", 32'(busy0), 32'(1));
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    build_frame(4, 1'b0, 1, st);
    run(st, 1'b1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory: the CPU fetches words from instruction memory, and this block fills it.
- Receives a byte stream framed as a program image and decrypts each payload byte with the same XOR key scheme the CPU's crypto op uses.
- Assembles 16-bit instruction words, writes them to the instruction-memory write port, and verifies a checksum.
- Holds the CPU off (`busy`) while loading and reports `done` or `error`.

Parameters:
- KEY, 8'h5A, XOR key applied to every payload byte (plaintext = in_data ^ KEY).
- BASE_ADDR, 8'h00, instruction address of the first loaded word.
- SYNC, 8'hA5, frame header byte.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte accepted when in_valid & in_ready at the clk edge.
- imem_we  output  1  instruction-memory write strobe, single cycle.
- imem_addr  output  8  write address.
- imem_wdata  output  16  write data, {hi byte, lo byte}.
- busy  output  1  high from header accept until DONE/ERR; the CPU is held while high.
- done  output  1  sticky: frame loaded and checksum good.
- error  output  1  sticky: zero length or checksum mismatch.
- words_loaded  output  8  count of words written in the current frame.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - in_ready=1; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0.
  - busy=0, done=0, error=0, words_loaded=0; internal len=0, csum=0.
- Frame format:
  - SYNC, LEN (plain, 1..255 words).
  - 2*LEN encrypted bytes, high byte first per word.
  - CSUM (plain).
  - CSUM must equal LEN ^ XOR of all decrypted payload bytes.
- States and transitions (only on accepted bytes unless noted):
  - IDLE: byte==SYNC -> LEN, busy=1, csum=0, words_loaded=0, imem_addr=BASE_ADDR. Any other byte is discarded.
  - LEN: len=byte, csum=byte. byte==0 -> ERR, otherwise -> HI.
  - HI: hi=byte^KEY, csum^=hi -> LO.
  - LO: lo=byte^KEY, csum^=lo. Next cycle imem_wdata={hi,lo}, imem_we=1 -> WR.
  - WR: one cycle, in_ready=0, imem_we=1 at current imem_addr. On exit, words_loaded+1 and imem_addr+1 (mod 256, wraps 8'hFF->8'h00). Then if words_loaded+1==len -> CSUM, else -> HI.
  - CSUM: byte==csum -> DONE (done=1), else -> ERR (error=1). busy=0 on either.
  - DONE/ERR: flags stay sticky. An accepted SYNC byte clears done/error and behaves as the IDLE SYNC transition. Other bytes are discarded.
- in_ready=1 in every state except WR.
- Write latency: imem_we asserts in the cycle after the LO byte is accepted, exactly one cycle wide.
- imem_addr/imem_wdata are stable while imem_we=1.
- Reset mid-frame aborts immediately to reset values. Memory contents already written are left as-is.
- A SYNC value arriving as LEN, payload, or CSUM is treated as data, not a resync.
- in_valid=0 stalls any state indefinitely with no timeout.

Decomposition:
- Shared package: state encoding (IDLE, LEN, HI, LO, WR, CSUM, DONE, ERR), the default SYNC constant, and the default KEY, so the CPU crypto path and the loader agree on the key.
- One natural sub-module: prog_byte_dec (registered XOR decrypt plus running-checksum accumulator, with clear and enable). Everything else stays inline.

Test Plan:
- Basic load, KEY=5A, BASE=00. Stream A5,02,48,6E,DA,5A,A4 -> writes 0x1234@00, 0x8000@01; done=1, error=0, busy=0, words_loaded=2.
- Bad checksum: same stream with last byte A5 -> both writes still occur; error=1, done=0.
- Zero length: A5,00 -> ERR immediately, no imem_we, error=1.
- Backpressure/stall: hold in_valid=1 continuously -> in_ready=0 exactly in each WR cycle, no byte lost. Insert random in_valid gaps -> identical memory result.
- Wrap and resync:
  - BASE=FE, LEN=3 -> writes at FE, FF, 00.
  - Leading garbage 00,11 before A5 is ignored.
  - After done, a second A5 frame clears done and reloads.
- Async reset: assert reset=0 mid-payload, between clk edges -> all outputs return to reset values immediately. A new frame after release loads correctly.
